shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Controller that sequences a WIDTH-bit bidirectional shift datapath. It accepts one command at a time over a valid/ready handshake: load, clear, shift left by N, or shift right by N, with logical-fill or rotate mode. It executes a shift command as N single-bit steps, one per clock, and holds the result register. It reports completion with a one-cycle done pulse. It sits between a command source (bus/FSM) and any logic consuming the shifted word.

Parameters:
WIDTH, 4, data word width in bits (>=2)
CNT_W, 3, width of shift-amount field; max amount 2^CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command (IDLE only)
cmd_op  input  2  00 load, 01 shift left, 10 shift right, 11 clear
cmd_rotate  input  1  1 = rotate, 0 = logical shift with fill_bit
cmd_amount  input  CNT_W  number of single-bit steps
cmd_data  input  WIDTH  operand for load/shift
fill_bit  input  1  value shifted into vacated bit (logical mode, sampled each step)
abort  input  1  cancel in-progress shift
data_out  output  WIDTH  result register
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle completion pulse
step_left  output  1  high in cycles where a left step is being applied
step_right  output  1  high in cycles where a right step is being applied

Behaviour:
- Reset (async, rst=1): state=IDLE, data_out=0, count=0, done=0, busy=0, cmd_ready=1 after release, step_left/right=0. Reset mid-operation discards the command immediately.
- States: IDLE, SHIFT, DONE. cmd_ready = (state==IDLE); busy = (state!=IDLE); done = (state==DONE).
- Accept = cmd_valid & cmd_ready at a rising edge. cmd_* ignored otherwise.
- On accept:
  - load: data_out<=cmd_data; go to DONE.
  - clear: data_out<=0; go to DONE.
  - shift with amount 0: data_out<=cmd_data; go to DONE.
  - shift with amount N>=1: data_out<=cmd_data, count<=N, latch direction/rotate; go to SHIFT.
- SHIFT: each edge applies one step to data_out and decrements count.
  - Left logical: {data_out[WIDTH-2:0], fill_bit}.
  - Right logical: {fill_bit, data_out[WIDTH-1:1]}.
  - Rotate left/right: the MSB or LSB wraps around.
  - The step that brings count from 1 to 0 goes to DONE.
  - step_left/step_right are high in every SHIFT cycle matching the latched direction; never both.
- Latency: for N>=1, exactly N SHIFT cycles; done is high in cycle N+1 after the accept edge. For load/clear/N=0, done is high in the cycle immediately after the accept edge.
- DONE: lasts exactly one cycle, then IDLE. The next accept is possible at the edge ending the first IDLE cycle, so back-to-back commands are spaced by N+2 cycles.
- Amount >= WIDTH:
  - Logical: all steps are still executed; the result is all fill bits (e.g. 0 when fill_bit=0).
  - Rotate: the result equals rotation by N mod WIDTH.
- abort: in SHIFT, the next edge goes to IDLE; data_out keeps the partial value, no done pulse, and no step is applied that edge. Ignored in IDLE and DONE.
- cmd_valid held high during busy: no effect; the command is accepted only once ready returns.
- data_out is stable in IDLE and DONE; it changes only on accept or a SHIFT step.

Test Plan:
1. Reset mid-shift: load cmd_data=4'b1011, left N=3, assert rst after 1 step -> data_out=0, busy=0, done never pulses; cmd_ready=1 after release.
2. Logical left: data=4'b0011, fill=0, N=2 -> step_left high 2 cycles, done in cycle 3 after accept, data_out=4'b1100. Then right N=1, fill=1, data=4'b1100 -> data_out=4'b1110.
3. Rotate right: data=4'b0001, N=5 -> data_out=4'b1000 (5 mod 4 = 1), 5 step_right cycles.
4. Zero/instant ops: shift N=0 data=4'b0110 -> data_out=4'b0110, done the next cycle, no step pulses. Clear -> data_out=0. Load 4'b1010 -> data_out=4'b1010.
5. Abort: data=4'b1111, left logical fill=0, N=4, abort after 2 steps -> data_out=4'b1100, state IDLE, no done pulse.
6. Handshake: cmd_valid held high with two queued commands -> second accepted only after done and one IDLE cycle; cmd_ready=0 throughout busy.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-driven controller for a WIDTH-bit bidirectional shift register.
// Loads, clears, or shifts the held word one bit per clock, then pulses done.
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_rotate,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             fill_bit,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             step_left,
  output logic             step_right
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               left_q, left_d;
  logic               rot_q, rot_d;
  logic               left_in, right_in;
  logic [WIDTH-1:0]   stepped;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      left_q  <= left_d;
      rot_q   <= rot_d;
    end
  end

  // Single-bit step of the held word; rotate wraps the bit that falls off
  always_comb begin
    left_in  = rot_q ? data_q[WIDTH-1] : fill_bit;
    right_in = rot_q ? data_q[0]       : fill_bit;
    if (left_q) stepped = {data_q[WIDTH-2:0], left_in};
    else        stepped = {right_in, data_q[WIDTH-1:1]};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    left_d  = left_q;
    rot_d   = rot_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              data_d  = cmd_data;
              state_d = S_DONE;
            end
            OP_CLEAR: begin
              data_d  = '0;
              state_d = S_DONE;
            end
            default: begin
              data_d = cmd_data;
              left_d = (cmd_op == OP_LEFT);
              rot_d  = cmd_rotate;
              if (cmd_amount == '0) begin
                state_d = S_DONE;
              end else begin
                count_d = cmd_amount;
                state_d = S_SHIFT;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (abort) begin
          count_d = '0;
          state_d = S_IDLE;
        end else begin
          data_d  = stepped;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    step_left  = (state_q == S_SHIFT) &&  left_q;
    step_right = (state_q == S_SHIFT) && !left_q;
    data_out   = data_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic
// model of each command's result, latency and step pulses.
module tb_shift_sequencer;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_rotate;
  logic [CW-1:0] cmd_amount;
  logic [W-1:0]  cmd_data;
  logic          fill_bit;
  logic          abort;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;
  logic          step_left;
  logic          step_right;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rotate(cmd_rotate), .cmd_amount(cmd_amount),
    .cmd_data(cmd_data), .fill_bit(fill_bit), .abort(abort),
    .data_out(data_out), .busy(busy), .done(done),
    .step_left(step_left), .step_right(step_right)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of a whole command as plain integer arithmetic
  function automatic logic [W-1:0] model(input logic [1:0] op, input bit rot,
                                         input int amt, input logic [W-1:0] d,
                                         input bit f);
    int v, mask, k, fm;
    mask = (1 << W) - 1;
    v = int'(d);
    if (op == 2'b00) return d;
    if (op == 2'b11) return '0;
    if (amt == 0) return d;
    if (rot) begin
      k = amt % W;
      if (k == 0) return d;
      if (op == 2'b01) v = ((v << k) | (v >> (W - k))) & mask;
      else             v = ((v >> k) | (v << (W - k))) & mask;
    end else if (amt >= W) begin
      v = f ? mask : 0;
    end else begin
      fm = f ? ((1 << amt) - 1) : 0;
      if (op == 2'b01) v = ((v << amt) & mask) | fm;
      else             v = (v >> amt) | (fm << (W - amt));
    end
    return W'(v);
  endfunction

  // Issues one command and records what the DUT did until it is idle again
  task automatic do_cmd(input logic [1:0] op, input bit rot, input int amt,
                        input logic [W-1:0] d, input bit f, input int abort_after,
                        output logic [W-1:0] res, output int lat, output int nl,
                        output int nr, output int ndone, output logic [W-1:0] ddata,
                        output int hs_bad);
    bit fin;
    nl = 0; nr = 0; ndone = 0; lat = -1; hs_bad = 0; ddata = 'x; fin = 0; res = 'x;
    for (int k = 0; k < 64 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1; cmd_op = op; cmd_rotate = rot;
    cmd_amount = CW'(amt); cmd_data = d; fill_bit = f;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = W'($urandom);
    cmd_amount = CW'($urandom); cmd_rotate = 1'($urandom);
    for (int c = 1; c <= 64 && !fin; c++) begin
      if (cmd_ready) begin
        fin = 1;
        res = data_out;
      end else begin
        if (cmd_ready == busy) hs_bad++;
        if (abort_after >= 0 && c == abort_after + 1) abort = 1'b1;
        if (!abort) begin
          nl += int'(step_left);
          nr += int'(step_right);
        end
        if (done) begin
          ndone++;
          lat = c;
          ddata = data_out;
        end
        tick();
        abort = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int ndone;
    rst = 1'b1;
    tick();
    checks++;
    if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        step_left !== 1'b0 || step_right !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%b busy=%b done=%b sl=%b sr=%b, want 0000 0 0 0 0",
               data_out, busy, done, step_left, step_right);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    // Reset in the middle of a left shift by 3
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rotate = 1'b0;
    cmd_amount = 3'd3; cmd_data = 4'b1011; fill_bit = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (data_out !== 4'b0110 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_prestep: data=%b busy=%b want 0110 1", data_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: data=%b busy=%b done=%b want 0000 0 0",
               data_out, busy, done);
    end
    ndone = 0;
    tick();
    ndone += int'(done);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      ndone += int'(done);
    end
    checks++;
    if (ndone != 0 || cmd_ready !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: done_pulses=%0d ready=%b data=%b want 0 1 0000",
               ndone, cmd_ready, data_out);
    end
  endtask

  task automatic test_logical();
    logic [W-1:0] res, dd; int lat, nl, nr, nd, hb;
    do_cmd(2'b01, 0, 2, 4'b0011, 0, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b1100 || lat != 3 || nl != 2 || nr != 0 || nd != 1 || hb != 0) begin
      errors++;
      $display("FAIL logical_left: res=%b lat=%0d nl=%0d nr=%0d nd=%0d hs=%0d want 1100 3 2 0 1 0",
               res, lat, nl, nr, nd, hb);
    end
    do_cmd(2'b10, 0, 1, 4'b1100, 1, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b1110 || lat != 2 || nl != 0 || nr != 1 || nd != 1) begin
      errors++;
      $display("FAIL logical_right: res=%b lat=%0d nl=%0d nr=%0d nd=%0d want 1110 2 0 1 1",
               res, lat, nl, nr, nd);
    end
  endtask

  task automatic test_rotate();
    logic [W-1:0] res, dd; int lat, nl, nr, nd, hb;
    do_cmd(2'b10, 1, 5, 4'b0001, 0, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b1000 || lat != 6 || nl != 0 || nr != 5 || nd != 1) begin
      errors++;
      $display("FAIL rotate_right: res=%b lat=%0d nl=%0d nr=%0d nd=%0d want 1000 6 0 5 1",
               res, lat, nl, nr, nd);
    end
  endtask

  task automatic test_instant();
    logic [W-1:0] res, dd; int lat, nl, nr, nd, hb;
    do_cmd(2'b01, 0, 0, 4'b0110, 1, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b0110 || lat != 1 || nl != 0 || nr != 0 || nd != 1) begin
      errors++;
      $display("FAIL zero_shift: res=%b lat=%0d nl=%0d nr=%0d nd=%0d want 0110 1 0 0 1",
               res, lat, nl, nr, nd);
    end
    do_cmd(2'b11, 0, 5, 4'b1111, 1, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b0000 || lat != 1 || nd != 1) begin
      errors++;
      $display("FAIL clear: res=%b lat=%0d nd=%0d want 0000 1 1", res, lat, nd);
    end
    do_cmd(2'b00, 0, 3, 4'b1010, 0, -1, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b1010 || lat != 1 || nl != 0 || nr != 0 || nd != 1) begin
      errors++;
      $display("FAIL load: res=%b lat=%0d nl=%0d nr=%0d nd=%0d want 1010 1 0 0 1",
               res, lat, nl, nr, nd);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] res, dd; int lat, nl, nr, nd, hb;
    do_cmd(2'b01, 0, 4, 4'b1111, 0, 2, res, lat, nl, nr, nd, dd, hb);
    checks++;
    if (res !== 4'b1100 || nl != 2 || nd != 0) begin
      errors++;
      $display("FAIL abort: res=%b steps=%0d done_pulses=%0d want 1100 2 0", res, nl, nd);
    end
  endtask

  task automatic test_back_to_back();
    int first_ready, bad_hs;
    logic [W-1:0] a_done;
    first_ready = -1; bad_hs = 0; a_done = 'x;
    for (int k = 0; k < 64 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rotate = 1'b0;
    cmd_amount = 3'd2; cmd_data = 4'b0011; fill_bit = 1'b0;
    tick();
    // Second command queued with valid held high while the first runs
    cmd_op = 2'b00; cmd_data = 4'b1010; cmd_amount = 3'd0;
    for (int c = 1; c <= 20 && first_ready < 0; c++) begin
      if (cmd_ready) first_ready = c;
      else begin
        if (busy !== 1'b1) bad_hs++;
        if (done) a_done = data_out;
        tick();
      end
    end
    checks++;
    if (first_ready != 4 || bad_hs != 0 || a_done !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_first: ready_cycle=%0d hs_bad=%0d done_data=%b want 4 0 1100",
               first_ready, bad_hs, a_done);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || data_out !== 4'b1010 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b data=%b ready=%b want 1 1010 0",
               done, data_out, cmd_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] res, dd, d, exp_res; int lat, nl, nr, nd, hb;
    logic [1:0] op; bit rot, f; int amt, exp_lat, exp_nl, exp_nr;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      rot = 1'($urandom);
      f   = 1'($urandom);
      amt = int'($urandom_range(0, 7));
      d   = W'($urandom);
      exp_res = model(op, rot, amt, d, f);
      if (op == 2'b01 || op == 2'b10) exp_lat = amt + 1;
      else exp_lat = 1;
      exp_nl = (op == 2'b01) ? amt : 0;
      exp_nr = (op == 2'b10) ? amt : 0;
      do_cmd(op, rot, amt, d, f, -1, res, lat, nl, nr, nd, dd, hb);
      checks++;
      if (res !== exp_res || dd !== exp_res || lat != exp_lat || nl != exp_nl ||
          nr != exp_nr || nd != 1 || hb != 0) begin
        errors++;
        $display("FAIL random[%0d] op=%0d rot=%0d amt=%0d d=%b f=%0d: res=%b done_data=%b lat=%0d nl=%0d nr=%0d nd=%0d hs=%0d want %b %b %0d %0d %0d 1 0",
                 i, op, rot, amt, d, f, res, dd, lat, nl, nr, nd, hb,
                 exp_res, exp_res, exp_lat, exp_nl, exp_nr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rotate = 1'b0;
    cmd_amount = '0; cmd_data = '0; fill_bit = 1'b0; abort = 1'b0;
    test_reset();
    test_logical();
    test_rotate();
    test_instant();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
